// File: rtl/vp_mem_pkg.sv
// Shared types and constants for the vp_mem wait-state memory controller.
package vp_mem_pkg;

   localparam int CNT_WIDTH = 4;
   localparam int MAX_WAIT  = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

endpackage

// File: rtl/vp_mem_if.sv
// Request/acknowledge bus between an initiator and vp_mem.
interface vp_mem_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
);
   logic                      CS;
   logic                      WE;
   logic                      RD;
   logic [DATA_WIDTH/8-1:0]   BE;
   logic [ADDR_WIDTH-1:0]     A;
   logic [DATA_WIDTH-1:0]     DI;
   logic [DATA_WIDTH-1:0]     DO;
   logic                      WRAck;
   logic                      RDAck;

   modport master (
      output CS, WE, RD, BE, A, DI,
      input  DO, WRAck, RDAck
   );

   modport slave (
      input  CS, WE, RD, BE, A, DI,
      output DO, WRAck, RDAck
   );
endinterface

// File: rtl/vp_mem_array.sv
// Word-addressed storage: byte-enabled synchronous write, synchronous read
// with write-first behaviour when both happen on the same edge. No reset.
module vp_mem_array #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic                    re,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);
   localparam int NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_r [0:(2**ADDR_WIDTH)-1];
   logic [DATA_WIDTH-1:0] rdata_r;
   logic [DATA_WIDTH-1:0] merged_s;

   function automatic logic [DATA_WIDTH-1:0] merge_bytes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [NB-1:0]         byte_en
   );
      logic [DATA_WIDTH-1:0] result;
      result = old_word;
      for (int i = 0; i < NB; i++) begin
         if (byte_en[i]) begin
            result[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            result[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return result;
   endfunction

   // Stored word with enabled bytes replaced, shared by write and write-first read.
   always_comb begin
      merged_s = merge_bytes(mem_r[addr], wdata, be);
   end

   // Storage update and registered read port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= merged_s;
      end
      if (re) begin
         rdata_r <= we ? merged_s : mem_r[addr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/vp_mem.sv
// Single-port memory with configurable read/write wait states and a
// one-cycle acknowledge pulse per completed request.
module vp_mem
   import vp_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int RD_WAIT    = 1,
   parameter int WR_WAIT    = 0
) (
   input  logic     clk,
   input  logic     reset,
   vp_mem_if.slave  bus
);
   localparam int NB = DATA_WIDTH / 8;
   localparam logic [CNT_WIDTH-1:0] RD_WAIT_C = CNT_WIDTH'(RD_WAIT);
   localparam logic [CNT_WIDTH-1:0] WR_WAIT_C = CNT_WIDTH'(WR_WAIT);

   if ((DATA_WIDTH <= 0) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_width
      $error("vp_mem: DATA_WIDTH must be a positive multiple of 8");
   end
   if ((RD_WAIT < 0) || (RD_WAIT > MAX_WAIT) || (WR_WAIT < 0) || (WR_WAIT > MAX_WAIT)) begin : g_bad_wait
      $error("vp_mem: RD_WAIT and WR_WAIT must be in 0..15");
   end

   state_t                  state_r, state_s;
   logic [CNT_WIDTH-1:0]    cnt_r, cnt_s;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [DATA_WIDTH-1:0]   wdata_r;
   logic [NB-1:0]           be_r;
   logic                    op_wr_r, op_rd_r;
   logic                    wr_ack_r, rd_ack_r;
   logic                    do_valid_r;

   logic                    req_s, abort_s, latch_s, commit_s;
   logic                    sel_wr_s, sel_rd_s;
   logic [CNT_WIDTH-1:0]    wait_sel_s;
   logic [ADDR_WIDTH-1:0]   mem_addr_s;
   logic [DATA_WIDTH-1:0]   mem_wdata_s;
   logic [NB-1:0]           mem_be_s;
   logic [DATA_WIDTH-1:0]   rdata_s;

   assign req_s = bus.CS & (bus.WE | bus.RD);

   // Next-state, wait counter and array-command decode.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      latch_s     = 1'b0;
      commit_s    = 1'b0;
      abort_s     = 1'b0;
      sel_wr_s    = op_wr_r;
      sel_rd_s    = op_rd_r;
      wait_sel_s  = bus.WE ? WR_WAIT_C : RD_WAIT_C;
      mem_addr_s  = addr_r;
      mem_wdata_s = wdata_r;
      mem_be_s    = be_r;
      case (state_r)
         IDLE: begin
            // A zero-wait request commits on its sampling edge, so feed the bus straight in.
            mem_addr_s  = bus.A;
            mem_wdata_s = bus.DI;
            mem_be_s    = bus.BE;
            sel_wr_s    = bus.WE;
            sel_rd_s    = bus.RD;
            if (req_s) begin
               latch_s = 1'b1;
               if (wait_sel_s != {CNT_WIDTH{1'b0}}) begin
                  state_s = WAIT;
                  cnt_s   = wait_sel_s;
               end else begin
                  state_s  = ACK;
                  cnt_s    = {CNT_WIDTH{1'b0}};
                  commit_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            abort_s = ~bus.CS | (op_wr_r & ~bus.WE) | (op_rd_r & ~bus.RD);
            if (abort_s) begin
               state_s = IDLE;
               cnt_s   = {CNT_WIDTH{1'b0}};
            end else if (cnt_r == {{(CNT_WIDTH-1){1'b0}}, 1'b1}) begin
               state_s  = ACK;
               cnt_s    = {CNT_WIDTH{1'b0}};
               commit_s = 1'b1;
            end else begin
               cnt_s = cnt_r - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
         end
         ACK: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            cnt_s   = {CNT_WIDTH{1'b0}};
         end
      endcase
   end

   // Controller state, request capture and acknowledge registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         cnt_r      <= {CNT_WIDTH{1'b0}};
         addr_r     <= {ADDR_WIDTH{1'b0}};
         wdata_r    <= {DATA_WIDTH{1'b0}};
         be_r       <= {NB{1'b0}};
         op_wr_r    <= 1'b0;
         op_rd_r    <= 1'b0;
         wr_ack_r   <= 1'b0;
         rd_ack_r   <= 1'b0;
         do_valid_r <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         wr_ack_r <= commit_s & sel_wr_s;
         rd_ack_r <= commit_s & sel_rd_s;
         if (commit_s & sel_rd_s) begin
            do_valid_r <= 1'b1;
         end
         if (latch_s) begin
            addr_r  <= bus.A;
            wdata_r <= bus.DI;
            be_r    <= bus.BE;
            op_wr_r <= bus.WE;
            op_rd_r <= bus.RD;
         end
      end
   end

   vp_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk   (clk),
      .we    (commit_s & sel_wr_s),
      .re    (commit_s & sel_rd_s),
      .be    (mem_be_s),
      .addr  (mem_addr_s),
      .wdata (mem_wdata_s),
      .rdata (rdata_s)
   );

   // The array read register has no reset; do_valid_r masks it to zero until the first read.
   assign bus.DO    = do_valid_r ? rdata_s : {DATA_WIDTH{1'b0}};
   assign bus.WRAck = wr_ack_r;
   assign bus.RDAck = rd_ack_r;

endmodule

// File: tb/tb_vp_mem.sv
// Self-checking bench for vp_mem: three parameterisations driven from one
// directed/random sequence and compared against a word-level memory model.
module tb_vp_mem;

   logic       clk;
   logic [2:0] rst;

   vp_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus0 ();
   vp_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus1 ();
   vp_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus2 ();

   vp_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RD_WAIT(1), .WR_WAIT(0))
      u0 (.clk(clk), .reset(rst[0]), .bus(bus0));
   vp_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RD_WAIT(3), .WR_WAIT(2))
      u1 (.clk(clk), .reset(rst[1]), .bus(bus1));
   vp_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RD_WAIT(5), .WR_WAIT(0))
      u2 (.clk(clk), .reset(rst[2]), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   bit [31:0]   mdl [int];
   logic [31:0] do_mdl [3];
   logic [9:0]  pool [8];

   function automatic int rd_w(input int s);
      case (s)
         0:       return 1;
         1:       return 3;
         default: return 5;
      endcase
   endfunction

   function automatic int wr_w(input int s);
      case (s)
         0:       return 0;
         1:       return 2;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] mask;
      mask = 32'h0;
      for (int i = 0; i < 4; i++)
         if (be[i]) mask = mask | (32'hFF << (8 * i));
      return (old_w & ~mask) | (new_w & mask);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int s, input logic cs, input logic we, input logic rd,
                        input logic [3:0] be, input logic [9:0] a, input logic [31:0] di);
      case (s)
         0: begin bus0.CS = cs; bus0.WE = we; bus0.RD = rd; bus0.BE = be; bus0.A = a; bus0.DI = di; end
         1: begin bus1.CS = cs; bus1.WE = we; bus1.RD = rd; bus1.BE = be; bus1.A = a; bus1.DI = di; end
         default: begin bus2.CS = cs; bus2.WE = we; bus2.RD = rd; bus2.BE = be; bus2.A = a; bus2.DI = di; end
      endcase
   endtask

   task automatic sample(input int s, output logic wa, output logic ra, output logic [31:0] dq);
      case (s)
         0: begin wa = bus0.WRAck; ra = bus0.RDAck; dq = bus0.DO; end
         1: begin wa = bus1.WRAck; ra = bus1.RDAck; dq = bus1.DO; end
         default: begin wa = bus2.WRAck; ra = bus2.RDAck; dq = bus2.DO; end
      endcase
   endtask

   // One complete request: expected latency, ack flags and DO come from the model.
   task automatic txn(input string tag, input int s, input logic we, input logic rd,
                      input logic [3:0] be, input logic [9:0] a, input logic [31:0] di,
                      output logic [31:0] got_do);
      int          w, n, key;
      logic        wa, ra, seen;
      logic [31:0] dq, old_w, new_w;
      key   = s * 1024 + int'(a);
      w     = we ? wr_w(s) : rd_w(s);
      old_w = mdl.exists(key) ? mdl[key] : 32'h0;
      new_w = we ? merge(old_w, di, be) : old_w;
      if (we) mdl[key] = new_w;
      if (rd) do_mdl[s] = new_w;
      @(negedge clk);
      drive(s, 1'b1, we, rd, be, a, di);
      n = 0; seen = 1'b0; wa = 1'b0; ra = 1'b0; dq = 32'h0;
      while (!seen && n < w + 10) begin
         @(posedge clk); #1;
         n++;
         sample(s, wa, ra, dq);
         seen = wa | ra;
      end
      check($sformatf("%s_latency", tag), n, 1 + w);
      check($sformatf("%s_acks", tag), {30'h0, wa, ra}, {30'h0, we, rd});
      check($sformatf("%s_do", tag), dq, do_mdl[s]);
      got_do = dq;
      drive(s, 1'b0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
      @(posedge clk); #1;
      sample(s, wa, ra, dq);
      check($sformatf("%s_pulse", tag), {30'h0, wa, ra}, 32'h0);
   endtask

   logic        wa, ra;
   logic [31:0] dq, got;
   int          acks, first_ack, second_ack;
   logic        any_ack;

   initial begin
      pool = '{10'h000, 10'h001, 10'h00A, 10'h07F, 10'h100, 10'h2AA, 10'h3FE, 10'h3FF};
      for (int s = 0; s < 3; s++) begin
         drive(s, 1'b0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
         do_mdl[s] = 32'h0;
      end
      rst = 3'b111;
      #2;
      for (int s = 0; s < 3; s++) begin
         sample(s, wa, ra, dq);
         check($sformatf("reset_state_%0d", s), {wa, ra, dq[29:0]}, 32'h0);
         check($sformatf("reset_do_%0d", s), dq, 32'h0);
      end
      @(negedge clk); @(negedge clk);
      rst = 3'b000;

      // Basic write then read with default waits.
      txn("wr005", 0, 1'b1, 1'b0, 4'hF, 10'h005, 32'h12345678, got);
      txn("rd005", 0, 1'b0, 1'b1, 4'hF, 10'h005, 32'h0, got);
      check("rd005_const", got, 32'h12345678);

      // Partial byte enables at the top address.
      txn("wr3ff_full", 0, 1'b1, 1'b0, 4'hF, 10'h3FF, 32'hFFFFFFFF, got);
      txn("wr3ff_be5",  0, 1'b1, 1'b0, 4'h5, 10'h3FF, 32'h00000000, got);
      txn("rd3ff",      0, 1'b0, 1'b1, 4'h0, 10'h3FF, 32'h0, got);
      check("rd3ff_const", got, 32'hFF00FF00);

      // Simultaneous write and read returns the new word.
      txn("wrrd010", 0, 1'b1, 1'b1, 4'hF, 10'h010, 32'hCAFEF00D, got);
      check("wrrd010_const", got, 32'hCAFEF00D);

      // Zero byte enables still acknowledge and leave the word alone.
      txn("wr005_be0", 0, 1'b1, 1'b0, 4'h0, 10'h005, 32'hA5A5A5A5, got);
      txn("rd005_be0", 0, 1'b0, 1'b1, 4'hF, 10'h005, 32'h0, got);
      check("rd005_be0_const", got, 32'h12345678);

      // Prefill an address pool, then random traffic against the model.
      for (int s = 0; s < 3; s++)
         for (int i = 0; i < 8; i++)
            txn($sformatf("fill%0d_%0d", s, i), s, 1'b1, 1'b0, 4'hF, pool[i], $urandom, got);
      for (int k = 0; k < 30; k++) begin
         int op, s;
         s  = $urandom_range(0, 2);
         op = $urandom_range(0, 2);
         txn($sformatf("rand%0d", k), s, op != 1, op != 0, 4'($urandom_range(0, 15)),
             pool[$urandom_range(0, 7)], $urandom, got);
      end

      // Held read with RD_WAIT=3: acks at edge 4, then every 5 edges.
      txn("wr040", 1, 1'b1, 1'b0, 4'hF, 10'h040, 32'h0BADF00D, got);
      @(negedge clk);
      drive(1, 1'b1, 1'b0, 1'b1, 4'h0, 10'h040, 32'h0);
      acks = 0; first_ack = 0; second_ack = 0;
      for (int e = 1; e <= 15; e++) begin
         @(posedge clk); #1;
         sample(1, wa, ra, dq);
         if (ra) begin
            acks++;
            if (acks == 1) first_ack = e;
            if (acks == 2) second_ack = e;
         end
      end
      drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
      check("b2b_first", first_ack, 4);
      check("b2b_period", second_ack - first_ack, 5);
      check("b2b_count", acks, 3);
      check("b2b_do", dq, 32'h0BADF00D);
      do_mdl[1] = 32'h0BADF00D;
      @(posedge clk); #1;

      // Chip select dropped mid-wait aborts the write.
      txn("wr020", 1, 1'b1, 1'b0, 4'hF, 10'h020, 32'h11112222, got);
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 1'b0, 4'hF, 10'h020, 32'hDEADBEEF);
      @(negedge clk);
      drive(1, 1'b0, 1'b1, 1'b0, 4'hF, 10'h020, 32'hDEADBEEF);
      any_ack = 1'b0;
      for (int e = 0; e < 6; e++) begin
         @(posedge clk); #1;
         sample(1, wa, ra, dq);
         any_ack = any_ack | wa | ra;
      end
      check("abort_noack", {31'h0, any_ack}, 32'h0);
      check("abort_do", dq, do_mdl[1]);
      drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
      txn("rd020", 1, 1'b0, 1'b1, 4'h0, 10'h020, 32'h0, got);
      check("rd020_const", got, 32'h11112222);

      // Reset pulsed while a RD_WAIT=5 read waits.
      txn("wr2_005", 2, 1'b1, 1'b0, 4'hF, 10'h005, 32'h5EED1234, got);
      txn("rd2_005", 2, 1'b0, 1'b1, 4'h0, 10'h005, 32'h0, got);
      @(negedge clk);
      drive(2, 1'b1, 1'b0, 1'b1, 4'h0, 10'h005, 32'h0);
      @(posedge clk); @(posedge clk); #3;
      rst[2] = 1'b1;
      #1;
      sample(2, wa, ra, dq);
      check("rst_acks", {30'h0, wa, ra}, 32'h0);
      check("rst_do", dq, 32'h0);
      do_mdl[2] = 32'h0;
      @(negedge clk);
      drive(2, 1'b0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
      @(negedge clk);
      rst[2] = 1'b0;
      txn("rd2_after_rst", 2, 1'b0, 1'b1, 4'h0, 10'h005, 32'h0, got);
      check("rd2_after_rst_const", got, 32'h5EED1234);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
